// File: rtl/mesi_com_bus_arbiter.sv
// Common-bus arbiter for the 4-core MESI cluster: round-robin proc tenures,
// with fixed-priority snoop grants nested inside an active proc tenure.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | bus free, searching proc requests from rr_ptr upward
// PROC       | one proc owner holds the bus, no snoop grant
// PROC_SNOOP | proc owner plus one snoop requester hold the bus
// TURN       | one-cycle turnaround with all grants low
module mesi_com_bus_arbiter #(
  parameter int NUM_PROC  = 8,
  parameter int NUM_SNOOP = 4,
  parameter int MAX_HOLD  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PROC-1:0]           Com_Bus_Req_proc,
  input  logic [NUM_SNOOP-1:0]          Com_Bus_Req_snoop,
  output logic [NUM_PROC-1:0]           Com_Bus_Gnt_proc,
  output logic [NUM_SNOOP-1:0]          Com_Bus_Gnt_snoop,
  output logic                          bus_busy,
  output logic [$clog2(NUM_PROC)-1:0]   owner_id,
  output logic                          timeout_err
);

  localparam int PW = $clog2(NUM_PROC);
  localparam int SW = $clog2(NUM_SNOOP);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PROC       = 2'd1,
    PROC_SNOOP = 2'd2,
    TURN       = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [NUM_PROC-1:0]  gnt_proc, gnt_proc_nx;
  logic [NUM_SNOOP-1:0] gnt_snoop, gnt_snoop_nx;
  logic [PW-1:0]        rr_ptr, rr_ptr_nx;
  logic [PW-1:0]        owner, owner_nx;
  logic [CW-1:0]        hold_cnt, hold_cnt_nx;

  logic                 rr_found;
  logic [PW-1:0]        rr_pick;
  logic [PW-1:0]        rr_cand;
  logic [NUM_SNOOP-1:0] own_mask;
  logic [NUM_SNOOP-1:0] snoop_avail;
  logic [NUM_SNOOP-1:0] snoop_pick;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = rr_ptr;
    rr_cand  = rr_ptr;
    for (int i = 0; i < NUM_PROC; i++) begin
      rr_cand = rr_ptr + PW'(i);
      if (!rr_found && Com_Bus_Req_proc[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  // The owner's own core (data or instruction side) is never snoop-granted.
  always_comb begin
    own_mask    = {{(NUM_SNOOP-1){1'b0}}, 1'b1} << owner[SW-1:0];
    snoop_avail = Com_Bus_Req_snoop & ~own_mask;
    snoop_pick  = '0;
    for (int j = NUM_SNOOP - 1; j >= 0; j--) begin
      if (snoop_avail[j]) snoop_pick = {{(NUM_SNOOP-1){1'b0}}, 1'b1} << j;
    end
  end

  always_comb begin
    state_nx     = state;
    gnt_proc_nx  = gnt_proc;
    gnt_snoop_nx = gnt_snoop;
    rr_ptr_nx    = rr_ptr;
    owner_nx     = owner;
    hold_cnt_nx  = hold_cnt;

    if ((state == PROC || state == PROC_SNOOP) && hold_cnt != CW'(MAX_HOLD))
      hold_cnt_nx = hold_cnt + CW'(1);

    case (state)
      IDLE: begin
        gnt_snoop_nx = '0;
        if (rr_found) begin
          gnt_proc_nx = {{(NUM_PROC-1){1'b0}}, 1'b1} << rr_pick;
          owner_nx    = rr_pick;
          hold_cnt_nx = '0;
          state_nx    = PROC;
        end
      end
      PROC: begin
        if (!Com_Bus_Req_proc[owner]) begin
          gnt_proc_nx  = '0;
          gnt_snoop_nx = '0;
          rr_ptr_nx    = owner + PW'(1);
          state_nx     = TURN;
        end else if (|snoop_avail) begin
          gnt_snoop_nx = snoop_pick;
          state_nx     = PROC_SNOOP;
        end
      end
      PROC_SNOOP: begin
        // Owner release is deferred until the snoop requester lets go.
        if (!(|(Com_Bus_Req_snoop & gnt_snoop))) begin
          gnt_snoop_nx = '0;
          state_nx     = PROC;
        end
      end
      TURN: begin
        gnt_proc_nx  = '0;
        gnt_snoop_nx = '0;
        state_nx     = IDLE;
      end
      default: begin
        gnt_proc_nx  = '0;
        gnt_snoop_nx = '0;
        state_nx     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_proc  <= '0;
      gnt_snoop <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      gnt_proc  <= gnt_proc_nx;
      gnt_snoop <= gnt_snoop_nx;
      rr_ptr    <= rr_ptr_nx;
      owner     <= owner_nx;
      hold_cnt  <= hold_cnt_nx;
    end
  end

  assign Com_Bus_Gnt_proc  = gnt_proc;
  assign Com_Bus_Gnt_snoop = gnt_snoop;
  assign bus_busy          = |gnt_proc;
  assign owner_id          = owner;
  // Counter saturates at MAX_HOLD, so this matches for one tenure cycle only.
  assign timeout_err       = bus_busy && (hold_cnt == CW'(MAX_HOLD - 1));

endmodule

// File: tb/tb_mesi_com_bus_arbiter.sv
// Self-checking bench for mesi_com_bus_arbiter: table-driven vectors plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_mesi_com_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_p;
  logic [3:0] req_s;
  logic [7:0] gnt_p;
  logic [3:0] gnt_s;
  logic       bus_busy;
  logic [2:0] owner_id;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] rp;
    logic [3:0] rs;
    logic [7:0] gp;
    logic [3:0] gs;
    logic       to;
  } vec_t;

  typedef struct {
    logic [7:0] gp;
    logic [3:0] gs;
    logic       to;
    string      nm;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[26];

  mesi_com_bus_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Com_Bus_Req_proc  (req_p),
    .Com_Bus_Req_snoop (req_s),
    .Com_Bus_Gnt_proc  (gnt_p),
    .Com_Bus_Gnt_snoop (gnt_s),
    .bus_busy          (bus_busy),
    .owner_id          (owner_id),
    .timeout_err       (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic check(input exp_t e);
    logic busy_e;
    logic own_ok;
    busy_e = |e.gp;
    own_ok = !busy_e || (int'(owner_id) == idx_of(e.gp));
    n_checks++;
    if (gnt_p !== e.gp || gnt_s !== e.gs || bus_busy !== busy_e ||
        !own_ok || timeout_err !== e.to) begin
      n_errors++;
      $display("FAIL %s: got gp=%h gs=%h busy=%b owner=%0d to=%b, need gp=%h gs=%h busy=%b owner=%0d to=%b",
               e.nm, gnt_p, gnt_s, bus_busy, owner_id, timeout_err,
               e.gp, e.gs, busy_e, idx_of(e.gp), e.to);
    end
  endtask

  task automatic step(input logic [7:0] rp, input logic [3:0] rs,
                      input logic [7:0] gp, input logic [3:0] gs,
                      input logic to, input string nm);
    exp_t e;
    req_p = rp;
    req_s = rs;
    e.gp = gp; e.gs = gs; e.to = to; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e);
  endtask

  task automatic check_zero(input string nm, input logic want_owner0);
    n_checks++;
    if (gnt_p !== 8'h00 || gnt_s !== 4'h0 || bus_busy !== 1'b0 ||
        timeout_err !== 1'b0 || (want_owner0 && owner_id !== 3'd0)) begin
      n_errors++;
      $display("FAIL %s: got gp=%h gs=%h busy=%b owner=%0d to=%b, need all zero",
               nm, gnt_p, gnt_s, bus_busy, owner_id, timeout_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] oh;
    logic [7:0] drop;

    // rp, rs, gp, gs, to: outputs expected after the edge that samples rp/rs
    tbl[0]  = '{8'h01, 4'h0, 8'h01, 4'h0, 1'b0};
    tbl[1]  = '{8'h01, 4'h0, 8'h01, 4'h0, 1'b0};
    tbl[2]  = '{8'h01, 4'h0, 8'h01, 4'h0, 1'b0};
    tbl[3]  = '{8'h01, 4'h0, 8'h01, 4'h0, 1'b0};
    tbl[4]  = '{8'h01, 4'h0, 8'h01, 4'h0, 1'b0};
    tbl[5]  = '{8'h00, 4'h0, 8'h00, 4'h0, 1'b0};
    tbl[6]  = '{8'h00, 4'h0, 8'h00, 4'h0, 1'b0};
    tbl[7]  = '{8'h03, 4'h0, 8'h02, 4'h0, 1'b0};
    tbl[8]  = '{8'h00, 4'h0, 8'h00, 4'h0, 1'b0};
    tbl[9]  = '{8'h00, 4'h0, 8'h00, 4'h0, 1'b0};
    tbl[10] = '{8'h10, 4'h0, 8'h10, 4'h0, 1'b0};
    tbl[11] = '{8'h10, 4'h3, 8'h10, 4'h2, 1'b0};
    tbl[12] = '{8'h10, 4'h3, 8'h10, 4'h2, 1'b0};
    tbl[13] = '{8'h10, 4'h1, 8'h10, 4'h0, 1'b0};
    tbl[14] = '{8'h10, 4'h1, 8'h10, 4'h0, 1'b0};
    tbl[15] = '{8'h00, 4'h0, 8'h00, 4'h0, 1'b0};
    tbl[16] = '{8'h00, 4'h0, 8'h00, 4'h0, 1'b0};
    tbl[17] = '{8'h02, 4'h0, 8'h02, 4'h0, 1'b0};
    tbl[18] = '{8'h02, 4'h6, 8'h02, 4'h4, 1'b0};
    tbl[19] = '{8'h00, 4'h6, 8'h02, 4'h4, 1'b0};
    tbl[20] = '{8'h00, 4'h6, 8'h02, 4'h4, 1'b0};
    tbl[21] = '{8'h00, 4'h2, 8'h02, 4'h0, 1'b0};
    tbl[22] = '{8'h00, 4'h2, 8'h00, 4'h0, 1'b0};
    tbl[23] = '{8'h00, 4'h0, 8'h00, 4'h0, 1'b0};
    tbl[24] = '{8'h00, 4'hF, 8'h00, 4'h0, 1'b0};
    tbl[25] = '{8'h00, 4'hF, 8'h00, 4'h0, 1'b0};

    rst_n = 1'b0;
    req_p = 8'h00;
    req_s = 4'h0;
    #12;
    check_zero("reset_values", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // single owner, rr advance, snoop mask, deferred release, IDLE snoop ignore
    for (int j = 0; j < 26; j++)
      step(tbl[j].rp, tbl[j].rs, tbl[j].gp, tbl[j].gs, tbl[j].to,
           $sformatf("table[%0d]", j));

    // async reset in PROC_SNOOP (rr_ptr is 2 here, owner 3)
    step(8'h08, 4'h0, 8'h08, 4'h0, 1'b0, "rst_grant3");
    step(8'h08, 4'h1, 8'h08, 4'h1, 1'b0, "rst_snoop0");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_drop", 1'b0);
    req_p = 8'h00;
    req_s = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // all requesting, each owner drops after three grant cycles; starts at 0
    for (int k = 0; k < 9; k++) begin
      oh   = 8'h01 << (k % 8);
      drop = 8'hFF & ~oh;
      step(8'hFF, 4'h0, oh,    4'h0, 1'b0, $sformatf("rr%0d_grant", k));
      step(8'hFF, 4'h0, oh,    4'h0, 1'b0, $sformatf("rr%0d_hold1", k));
      step(8'hFF, 4'h0, oh,    4'h0, 1'b0, $sformatf("rr%0d_hold2", k));
      step(drop,  4'h0, 8'h00, 4'h0, 1'b0, $sformatf("rr%0d_turn", k));
      step(drop,  4'h0, 8'h00, 4'h0, 1'b0, $sformatf("rr%0d_idle", k));
    end

    // owner 3 holds 70 cycles: pulse only on tenure cycle 64, grant kept
    step(8'h08, 4'h0, 8'h08, 4'h0, 1'b0, "hold_t1");
    for (int t = 2; t <= 70; t++)
      step(8'h08, 4'h0, 8'h08, 4'h0, (t == 64), $sformatf("hold_t%0d", t));
    step(8'h00, 4'h0, 8'h00, 4'h0, 1'b0, "hold_release");
    step(8'h00, 4'h0, 8'h00, 4'h0, 1'b0, "hold_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
